display_scan_controller: RTL and testbench

- Scans the front buffer of the double-buffered display memory onto a HUB75-style LED panel using binary-code modulation (BCM).
- Generates the memory read addresses and the flip select.
- Drives panel shift clock, latch, output enable, row address and serial colour bits.
- Swaps front/back buffers only at frame boundaries, on request from the frame writer.

---
 rtl/display_scan_controller.sv | 187 ++++++++++++++++++
 tb/tb_display_scan_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// Display scan controller: scans the front display buffer onto a HUB75-style
// LED panel using binary-code modulation, and flips buffers only between frames.
module display_scan_controller #(
  parameter int unsigned segments    = 1,
  parameter int unsigned rows        = 8,
  parameter int unsigned columns     = 32,
  parameter int unsigned width       = 24,
  parameter int unsigned base_cycles = 4,
  localparam int unsigned row_w = (rows > 1) ? $clog2(rows) : 1,
  localparam int unsigned col_w = (columns > 1) ? $clog2(columns) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        swap_req,
  output logic                        swap_done,
  output logic                        flip,
  output logic [row_w-1:0]            rrow,
  output logic [col_w-1:0]            rcol,
  input  logic [width*segments-1:0]   rdata,
  output logic                        panel_clk,
  output logic                        panel_lat,
  output logic                        panel_oe_n,
  output logic [row_w-1:0]            panel_row,
  output logic [3*segments-1:0]       panel_data
);

  localparam int unsigned bits      = width / 3;
  localparam int unsigned bit_w     = (bits > 1) ? $clog2(bits) : 1;
  localparam int unsigned shift_len = 2 * columns + 2;
  localparam int unsigned disp_max  = base_cycles << (bits - 1);
  localparam int unsigned max_len   = (shift_len > disp_max) ? shift_len : disp_max;
  localparam int unsigned cnt_w     = $clog2(max_len + 1);

  typedef enum logic [2:0] {
    IDLE, SHIFT, BLANK, LATCH, DISPLAY, FRAME_END
  } state_t;

  state_t             state, state_nxt;
  logic [cnt_w-1:0]   k, k_nxt;
  logic [row_w-1:0]   r, r_nxt;
  logic [bit_w-1:0]   b, b_nxt;
  logic               pending, pending_nxt;
  logic               flip_nxt, swap_done_nxt;
  logic [row_w-1:0]   rrow_nxt, panel_row_nxt;
  logic [col_w-1:0]   rcol_nxt;
  logic               panel_clk_nxt, panel_lat_nxt, panel_oe_n_nxt;
  logic [3*segments-1:0] panel_data_nxt;
  logic [cnt_w-1:0]   disp_len;

  // On-time of the current bit plane doubles with each plane.
  assign disp_len = cnt_w'(base_cycles) << b;

  // Selects bit plane sel of the r, g and b fields of one pixel.
  function automatic logic [2:0] plane_bits(input logic [width-1:0] pix,
                                            input logic [bit_w-1:0] sel);
    logic [bits-1:0] rc, gc, bc;
    rc = pix[width-1 -: bits];
    gc = pix[2*bits-1 -: bits];
    bc = pix[bits-1:0];
    return {rc[sel], gc[sel], bc[sel]};
  endfunction

  // Next-state logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_nxt     = state;
    k_nxt         = k;
    r_nxt         = r;
    b_nxt         = b;
    pending_nxt   = pending | swap_req;
    flip_nxt      = flip;
    swap_done_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (pending_nxt) begin
          flip_nxt      = ~flip;
          swap_done_nxt = 1'b1;
          pending_nxt   = 1'b0;
        end
        if (enable) begin
          state_nxt = SHIFT;
          k_nxt     = '0;
          r_nxt     = '0;
          b_nxt     = '0;
        end
      end
      SHIFT: begin
        if (k == cnt_w'(shift_len - 1)) begin
          state_nxt = BLANK;
          k_nxt     = '0;
        end else begin
          k_nxt = k + cnt_w'(1);
        end
      end
      BLANK: state_nxt = LATCH;
      LATCH: begin
        state_nxt = DISPLAY;
        k_nxt     = '0;
      end
      DISPLAY: begin
        if (k == disp_len - cnt_w'(1)) begin
          k_nxt     = '0;
          state_nxt = SHIFT;
          if (b != bit_w'(bits - 1)) begin
            b_nxt = b + bit_w'(1);
          end else begin
            b_nxt = '0;
            if (r != row_w'(rows - 1)) r_nxt = r + row_w'(1);
            else                       state_nxt = FRAME_END;
          end
        end else begin
          k_nxt = k + cnt_w'(1);
        end
      end
      FRAME_END: begin
        if (pending_nxt) begin
          flip_nxt      = ~flip;
          swap_done_nxt = 1'b1;
          pending_nxt   = 1'b0;
        end
        k_nxt = '0;
        r_nxt = '0;
        b_nxt = '0;
        state_nxt = enable ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    rrow_nxt       = rrow;
    rcol_nxt       = rcol;
    panel_row_nxt  = panel_row;
    panel_data_nxt = panel_data;
    panel_clk_nxt  = 1'b0;
    panel_lat_nxt  = (state_nxt == LATCH);
    panel_oe_n_nxt = (state_nxt != DISPLAY);

    if (state_nxt == SHIFT) begin
      rrow_nxt = r_nxt;
      if ((k_nxt >> 1) < cnt_w'(columns)) rcol_nxt = col_w'(k_nxt >> 1);
      else                                rcol_nxt = col_w'(columns - 1);
      panel_clk_nxt = (k_nxt >= cnt_w'(3)) && k_nxt[0];
      // rdata now answers the address shown two phases ago; hold it for two cycles.
      if ((k_nxt >= cnt_w'(2)) && !k_nxt[0]) begin
        for (int unsigned s = 0; s < segments; s++)
          panel_data_nxt[3*s +: 3] = plane_bits(rdata[s*width +: width], b_nxt);
      end
    end
    if (state_nxt == LATCH) panel_row_nxt = r_nxt;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= '0;
      r          <= '0;
      b          <= '0;
      pending    <= 1'b0;
      flip       <= 1'b0;
      swap_done  <= 1'b0;
      rrow       <= '0;
      rcol       <= '0;
      panel_clk  <= 1'b0;
      panel_lat  <= 1'b0;
      panel_oe_n <= 1'b1;
      panel_row  <= '0;
      panel_data <= '0;
    end else begin
      state      <= state_nxt;
      k          <= k_nxt;
      r          <= r_nxt;
      b          <= b_nxt;
      pending    <= pending_nxt;
      flip       <= flip_nxt;
      swap_done  <= swap_done_nxt;
      rrow       <= rrow_nxt;
      rcol       <= rcol_nxt;
      panel_clk  <= panel_clk_nxt;
      panel_lat  <= panel_lat_nxt;
      panel_oe_n <= panel_oe_n_nxt;
      panel_row  <= panel_row_nxt;
      panel_data <= panel_data_nxt;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: small panel (2 rows x 4 columns, 2-bit colour),
// scoreboard queues for shifted data, latch rows, on-time runs and buffer swaps.
module tb_display_scan_controller;

  logic       clk = 1'b0;
  logic       rst_n, enable, swap_req;
  logic       swap_done, flip;
  logic [0:0] rrow;
  logic [1:0] rcol;
  logic [5:0] rdata = '0;
  logic       panel_clk, panel_lat, panel_oe_n;
  logic [0:0] panel_row;
  logic [2:0] panel_data;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int clk_rises = 0, lat_cnt = 0, oe_low_cnt = 0;
  int t0, t1, lat0, oe0, rises0;

  logic [2:0] q_data[$];
  int         q_row[$];
  int         q_oe[$];
  logic       q_flip[$];

  display_scan_controller #(
    .segments(1), .rows(2), .columns(4), .width(6), .base_cycles(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .swap_req(swap_req),
    .swap_done(swap_done), .flip(flip), .rrow(rrow), .rcol(rcol), .rdata(rdata),
    .panel_clk(panel_clk), .panel_lat(panel_lat), .panel_oe_n(panel_oe_n),
    .panel_row(panel_row), .panel_data(panel_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pixel = {red=col, green=~col, blue={row,flip}}; one-cycle read latency.
  function automatic logic [5:0] mem_pix(input logic f, input logic [0:0] r, input logic [1:0] c);
    return {c, ~c, r, f};
  endfunction

  always @(posedge clk) rdata <= mem_pix(flip, rrow, rcol);

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  task automatic to_cycle(input int t);
    while (cyc < t) @(negedge clk);
    #1;
  endtask

  // Expected events for the first n (row, plane) pairs of a frame read from buffer f.
  task automatic push_planes(input logic f, input int n, input bit with_oe);
    for (int i = 0; i < n; i++) begin
      int r, b;
      logic [5:0] p;
      r = i / 2;
      b = i % 2;
      for (int c = 0; c < 4; c++) begin
        p = mem_pix(f, 1'(r), 2'(c));
        q_data.push_back({p[4+b], p[2+b], p[b]});
      end
      q_row.push_back(r);
      if (with_oe) q_oe.push_back(2 << b);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " flip"}, int'(flip), 0);
    check({tag, " panel_oe_n"}, int'(panel_oe_n), 1);
    check({tag, " panel_clk"}, int'(panel_clk), 0);
    check({tag, " panel_lat"}, int'(panel_lat), 0);
    check({tag, " panel_data"}, int'(panel_data), 0);
    check({tag, " panel_row"}, int'(panel_row), 0);
    check({tag, " rrow"}, int'(rrow), 0);
    check({tag, " rcol"}, int'(rcol), 0);
    check({tag, " swap_done"}, int'(swap_done), 0);
  endtask

  // Monitor: pops the scoreboard whenever the panel presents an event.
  initial begin
    logic       prev_clk, prev_flip, prev_valid, ef;
    logic [2:0] prev_data, ed;
    int         oe_run, er;
    prev_clk = 0; prev_flip = 0; prev_valid = 0; prev_data = '0; oe_run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        oe_run = 0;
        prev_valid = 0;
      end else begin
        if (panel_clk && !prev_clk) begin
          clk_rises++;
          if (q_data.size() == 0) fail_evt("unexpected panel_clk");
          else begin
            ed = q_data.pop_front();
            check("data before clk edge", int'(prev_data), int'(ed));
            check("data during clk high", int'(panel_data), int'(ed));
          end
        end
        if (panel_lat) begin
          lat_cnt++;
          if (q_row.size() == 0) fail_evt("unexpected panel_lat");
          else begin
            er = q_row.pop_front();
            check("panel_row at latch", int'(panel_row), er);
          end
        end
        if (swap_done) begin
          if (q_flip.size() == 0) fail_evt("unexpected swap_done");
          else begin
            ef = q_flip.pop_front();
            check("flip at swap_done", int'(flip), int'(ef));
          end
        end else if (prev_valid && flip != prev_flip) begin
          fail_evt("flip change without swap_done");
        end
        if (!panel_oe_n) begin
          oe_run++;
          oe_low_cnt++;
        end else if (oe_run != 0) begin
          if (q_oe.size() == 0) fail_evt("unexpected oe run");
          else begin
            er = q_oe.pop_front();
            check("oe low run length", oe_run, er);
          end
          oe_run = 0;
        end
        prev_valid = 1;
      end
      prev_clk  = panel_clk;
      prev_data = panel_data;
      prev_flip = flip;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Stimulus: directed frames with swap, enable and reset events at fixed cycles.
  initial begin
    rst_n = 1; enable = 0; swap_req = 0;
    #1 rst_n = 0;
    to_cycle(2);
    check_reset("reset");
    to_cycle(4);
    rst_n = 1;
    to_cycle(6);
    check("idle oe_n", int'(panel_oe_n), 1);
    check("idle flip", int'(flip), 0);

    // Frames A (flip 0), B (flip 1), C (flip 0).
    t0 = cyc;
    push_planes(1'b0, 4, 1'b1);
    push_planes(1'b1, 4, 1'b1);
    push_planes(1'b0, 4, 1'b1);
    q_flip.push_back(1'b1);
    q_flip.push_back(1'b0);
    enable = 1;
    to_cycle(t0 + 1);
    check("first shift rrow", int'(rrow), 0);
    check("first shift rcol", int'(rcol), 0);
    check("first shift oe_n", int'(panel_oe_n), 1);
    to_cycle(t0 + 11);
    lat0 = lat_cnt;
    oe0  = oe_low_cnt;
    to_cycle(t0 + 12);
    check("first latch cycle", int'(panel_lat), 1);
    to_cycle(t0 + 20); swap_req = 1;
    to_cycle(t0 + 21); swap_req = 0;
    to_cycle(t0 + 40); swap_req = 1;
    to_cycle(t0 + 41); swap_req = 0;
    check("flip mid-frame", int'(flip), 0);
    to_cycle(t0 + 61);
    check("flip in frame_end", int'(flip), 0);
    to_cycle(t0 + 62);
    check("flip after frame A", int'(flip), 1);
    check("swap_done after frame A", int'(swap_done), 1);
    to_cycle(t0 + 63);
    check("swap_done single pulse", int'(swap_done), 0);
    to_cycle(t0 + 72);
    check("latches per frame", lat_cnt - lat0, 4);
    check("oe low cycles per frame", oe_low_cnt - oe0, 12);
    to_cycle(t0 + 73);
    check("frame period 61", int'(panel_lat), 1);

    to_cycle(t0 + 122);
    check("no toggle in frame B", int'(flip), 1);
    swap_req = 1;
    to_cycle(t0 + 123);
    swap_req = 0;
    check("flip after frame_end swap_req", int'(flip), 0);
    check("swap_done after frame_end swap_req", int'(swap_done), 1);

    to_cycle(t0 + 142);
    enable = 0;
    to_cycle(t0 + 184);
    check("idle after frame C", int'(panel_oe_n), 1);
    rises0 = clk_rises;
    to_cycle(t0 + 199);
    check("no panel_clk in idle", clk_rises - rises0, 0);

    q_flip.push_back(1'b1);
    to_cycle(t0 + 200); swap_req = 1;
    to_cycle(t0 + 201); swap_req = 0;
    check("idle swap flip", int'(flip), 1);
    check("idle swap_done", int'(swap_done), 1);
    to_cycle(t0 + 202);
    check("idle swap_done single", int'(swap_done), 0);

    // Frame D is cut by reset in its first display window.
    push_planes(1'b1, 1, 1'b0);
    to_cycle(t0 + 205); enable = 1;
    to_cycle(t0 + 218);
    check("display before reset", int'(panel_oe_n), 0);
    check("flip before reset", int'(flip), 1);
    #1 rst_n = 0;
    #1 check_reset("reset in display");
    to_cycle(t0 + 222);
    rst_n = 1;
    t1 = cyc;
    push_planes(1'b0, 4, 1'b1);
    to_cycle(t1 + 1);
    check("restart rrow", int'(rrow), 0);
    check("restart rcol", int'(rcol), 0);
    check("restart flip", int'(flip), 0);
    check("restart oe_n", int'(panel_oe_n), 1);
    to_cycle(t1 + 30);
    enable = 0;
    to_cycle(t1 + 75);
    check("final idle oe_n", int'(panel_oe_n), 1);
    check("data events left", q_data.size(), 0);
    check("latch events left", q_row.size(), 0);
    check("oe runs left", q_oe.size(), 0);
    check("swap events left", q_flip.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
